// File: rtl/cpu_fetch.sv
// Rv32H instruction fetch stage: one-word bus read per fetch strobe, done pulse to decode, bus-wait timeout fault.
// Optional misaligned-PC fault enabled by defining CPU_FETCH_ALIGN_CHECK_EN.
module cpu_fetch #(
    parameter int unsigned TIMEOUT_CYCLES    = 256,
    parameter logic [31:0] RESET_INSTRUCTION = 32'h00000013
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_fetch,
    input  logic [31:0] i_pc,
    output logic        o_bus_request,
    output logic [31:0] o_bus_address,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic        o_fetched,
    output logic        o_busy,
    output logic        o_fault,
    output logic        o_fault_cause
);

    localparam int unsigned CW   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned TLIM = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CW-1:0] LIMIT = CW'(TLIM);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_count, w_count_next;
    logic [31:0]   r_pend_pc, w_pend_pc_next;
    logic          r_bus_request, w_bus_request_next;
    logic [31:0]   r_bus_address, w_bus_address_next;
    logic [31:0]   r_instruction, w_instruction_next;
    logic [31:0]   r_pc, w_pc_next;
    logic          r_fetched, w_fetched_next;
    logic          r_fault, w_fault_next;
    logic          r_fault_cause, w_fault_cause_next;
    logic          w_misaligned;

`ifdef CPU_FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (i_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_pend_pc     <= '0;
            r_bus_request <= 1'b0;
            r_bus_address <= '0;
            r_instruction <= RESET_INSTRUCTION;
            r_pc          <= '0;
            r_fetched     <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_pend_pc     <= w_pend_pc_next;
            r_bus_request <= w_bus_request_next;
            r_bus_address <= w_bus_address_next;
            r_instruction <= w_instruction_next;
            r_pc          <= w_pc_next;
            r_fetched     <= w_fetched_next;
            r_fault       <= w_fault_next;
            r_fault_cause <= w_fault_cause_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_count_next       = r_count;
        w_pend_pc_next     = r_pend_pc;
        w_bus_request_next = r_bus_request;
        w_bus_address_next = r_bus_address;
        w_instruction_next = r_instruction;
        w_pc_next          = r_pc;
        w_fetched_next     = 1'b0;
        w_fault_next       = 1'b0;
        w_fault_cause_next = r_fault_cause;
        case (r_state)
            S_IDLE: begin
                if (i_fetch) begin
                    if (w_misaligned) begin
                        w_fault_next       = 1'b1;
                        w_fault_cause_next = 1'b1;
                    end else begin
                        w_pend_pc_next     = i_pc;
                        w_bus_address_next = {i_pc[31:2], 2'b00};
                        w_bus_request_next = 1'b1;
                        w_count_next       = '0;
                        w_state_next       = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A ready in the timeout cycle still completes the fetch.
                if (i_bus_ready) begin
                    w_instruction_next = i_bus_rdata;
                    w_pc_next          = r_pend_pc;
                    w_fetched_next     = 1'b1;
                    w_bus_request_next = 1'b0;
                    w_state_next       = S_IDLE;
                end else if ((TIMEOUT_CYCLES != 0) && (r_count == LIMIT)) begin
                    w_bus_request_next = 1'b0;
                    w_fault_next       = 1'b1;
                    w_fault_cause_next = 1'b0;
                    w_state_next       = S_IDLE;
                end else if (r_count != '1) begin
                    w_count_next = r_count + CW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_bus_address;
    assign o_instruction = r_instruction;
    assign o_pc          = r_pc;
    assign o_fetched     = r_fetched;
    assign o_busy        = (r_state == S_WAIT);
    assign o_fault       = r_fault;
    assign o_fault_cause = r_fault_cause;

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: transaction-level reference model checked every cycle plus literal expectations.
module tb_cpu_fetch;

    localparam int unsigned TO = 4;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, fetch, ready_drv, zw;
    logic [31:0] pc, rdata_drv;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        o_bus_request, o_fetched, o_busy, o_fault, o_fault_cause;
    logic [31:0] o_bus_address, o_instruction, o_pc;

    int n_checks = 0;
    int n_errors = 0;
    int n_fetched = 0;
    int base;

    // Model of the fetch stage, in terms of "a transaction is outstanding" and its elapsed wait.
    bit          started = 1'b0;
    bit          m_busy;
    int          m_wait;
    logic [31:0] m_pend, m_addr, m_instr, m_pc;
    logic        m_req, m_fetched, m_fault, m_cause;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h10000013 + a;
    endfunction

    assign bus_ready = zw ? o_bus_request : ready_drv;
    assign bus_rdata = zw ? mem(o_bus_address) : rdata_drv;

    cpu_fetch #(.TIMEOUT_CYCLES(TO), .RESET_INSTRUCTION(32'h00000013)) dut (
        .i_clock(clk), .i_reset(rst), .i_fetch(fetch), .i_pc(pc),
        .o_bus_request(o_bus_request), .o_bus_address(o_bus_address),
        .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata),
        .o_instruction(o_instruction), .o_pc(o_pc), .o_fetched(o_fetched),
        .o_busy(o_busy), .o_fault(o_fault), .o_fault_cause(o_fault_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        logic rdy;
        logic [31:0] data;
        if (rst) begin
            started   <= 1'b1;
            m_busy    <= 1'b0; m_wait <= 0; m_pend <= '0;
            m_req     <= 1'b0; m_addr <= '0;
            m_instr   <= 32'h00000013; m_pc <= '0;
            m_fetched <= 1'b0; m_fault <= 1'b0; m_cause <= 1'b0;
        end else begin
            m_fetched <= 1'b0;
            m_fault   <= 1'b0;
            if (!m_busy) begin
                if (fetch) begin
                    if (ALIGN && pc[1:0] != 2'b00) begin
                        m_fault <= 1'b1; m_cause <= 1'b1;
                    end else begin
                        m_busy <= 1'b1; m_req <= 1'b1; m_wait <= 0;
                        m_addr <= pc & 32'hFFFFFFFC; m_pend <= pc;
                    end
                end
            end else begin
                rdy  = zw ? 1'b1 : ready_drv;
                data = zw ? mem(m_addr) : rdata_drv;
                if (rdy) begin
                    m_busy <= 1'b0; m_req <= 1'b0; m_fetched <= 1'b1;
                    m_instr <= data; m_pc <= m_pend;
                end else if (m_wait + 1 >= TO) begin
                    m_busy <= 1'b0; m_req <= 1'b0; m_fault <= 1'b1; m_cause <= 1'b0;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk1("m_bus_request", o_bus_request, m_req);
            chk ("m_bus_address", o_bus_address, m_addr);
            chk ("m_instruction", o_instruction, m_instr);
            chk ("m_pc",          o_pc,          m_pc);
            chk1("m_fetched",     o_fetched,     m_fetched);
            chk1("m_busy",        o_busy,        m_busy);
            chk1("m_fault",       o_fault,       m_fault);
            if (m_fault) chk1("m_fault_cause", o_fault_cause, m_cause);
            if (o_fetched === 1'b1) n_fetched++;
        end
    end

    initial begin
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc = '{32'h0, 32'h4, 32'h8};
        exp_in = '{32'h10000013, 32'h10000017, 32'h1000001B};
        rst = 1'b1; fetch = 1'b0; pc = '0; ready_drv = 1'b0; rdata_drv = '0; zw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset; a stray ready in IDLE must be ignored
        repeat (2) @(negedge clk);
        ready_drv = 1'b1; rdata_drv = 32'hFFFFFFFF;
        @(negedge clk);
        ready_drv = 1'b0;
        repeat (2) @(negedge clk);
        chk ("rst_instruction", o_instruction, 32'h00000013);
        chk1("rst_fetched", o_fetched, 1'b0);
        chk1("rst_request", o_bus_request, 1'b0);
        chk1("rst_busy", o_busy, 1'b0);
        chk ("rst_pc", o_pc, 32'h0);

        // Single fetch, ready three cycles after request, fetch during WAIT ignored
        base = n_fetched;
        fetch = 1'b1; pc = 32'h00000100;
        @(negedge clk);
        fetch = 1'b0;
        chk1("s2_request", o_bus_request, 1'b1);
        chk ("s2_address", o_bus_address, 32'h00000100);
        chk1("s2_busy", o_busy, 1'b1);
        @(negedge clk);
        fetch = 1'b1; pc = 32'h00000200;
        @(negedge clk);
        fetch = 1'b0;
        chk ("s2_address_hold", o_bus_address, 32'h00000100);
        ready_drv = 1'b1; rdata_drv = 32'h00A00093;
        @(negedge clk);
        ready_drv = 1'b0;
        chk1("s2_fetched", o_fetched, 1'b1);
        chk ("s2_instruction", o_instruction, 32'h00A00093);
        chk ("s2_pc", o_pc, 32'h00000100);
        chk1("s2_request_drop", o_bus_request, 1'b0);
        repeat (3) @(negedge clk);
        chk ("s2_pulse_count", n_fetched - base, 1);
        chk ("s2_instruction_hold", o_instruction, 32'h00A00093);

        // Zero-wait bus, back-to-back fetches
        zw = 1'b1; base = n_fetched;
        fetch = 1'b1; pc = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            fetch = 1'b0;
            @(negedge clk);
            chk1("zw_fetched", o_fetched, 1'b1);
            chk ("zw_pc", o_pc, exp_pc[k]);
            chk ("zw_instruction", o_instruction, exp_in[k]);
            if (k < 2) begin
                fetch = 1'b1; pc = exp_pc[k+1];
            end
        end
        @(negedge clk);
        zw = 1'b0;
        repeat (2) @(negedge clk);
        chk ("zw_pulse_count", n_fetched - base, 3);

        // Timeout with no ready
        fetch = 1'b1; pc = 32'h00000300;
        @(negedge clk);
        fetch = 1'b0;
        repeat (3) @(negedge clk);
        chk1("to_request_held", o_bus_request, 1'b1);
        @(negedge clk);
        chk1("to_fault", o_fault, 1'b1);
        chk1("to_cause", o_fault_cause, 1'b0);
        chk1("to_request_drop", o_bus_request, 1'b0);
        chk1("to_no_fetched", o_fetched, 1'b0);
        chk ("to_instruction", o_instruction, 32'h1000001B);
        chk ("to_pc", o_pc, 32'h00000008);
        @(negedge clk);
        chk1("to_fault_pulse", o_fault, 1'b0);

        // Ready on the last WAIT cycle wins over timeout
        fetch = 1'b1; pc = 32'h00000304;
        @(negedge clk);
        fetch = 1'b0;
        repeat (3) @(negedge clk);
        ready_drv = 1'b1; rdata_drv = 32'h00500113;
        @(negedge clk);
        ready_drv = 1'b0;
        chk1("tr_fetched", o_fetched, 1'b1);
        chk1("tr_no_fault", o_fault, 1'b0);
        chk ("tr_instruction", o_instruction, 32'h00500113);
        chk ("tr_pc", o_pc, 32'h00000304);

        // Reset in the middle of WAIT, late ready ignored
        @(negedge clk);
        base = n_fetched;
        fetch = 1'b1; pc = 32'h00000400;
        @(negedge clk);
        fetch = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk1("mr_request", o_bus_request, 1'b0);
        chk1("mr_busy", o_busy, 1'b0);
        chk ("mr_instruction", o_instruction, 32'h00000013);
        ready_drv = 1'b1; rdata_drv = 32'hBAD00BAD;
        repeat (2) @(negedge clk);
        ready_drv = 1'b0;
        @(negedge clk);
        chk ("mr_no_pulse", n_fetched - base, 0);
        chk ("mr_instruction_hold", o_instruction, 32'h00000013);

        // Misaligned PC
        fetch = 1'b1; pc = 32'h00000102;
        @(negedge clk);
        fetch = 1'b0;
`ifdef CPU_FETCH_ALIGN_CHECK_EN
        chk1("al_no_request", o_bus_request, 1'b0);
        chk1("al_fault", o_fault, 1'b1);
        chk1("al_cause", o_fault_cause, 1'b1);
        chk ("al_pc", o_pc, 32'h0);
        @(negedge clk);
        chk1("al_fault_pulse", o_fault, 1'b0);
`else
        chk1("al_request", o_bus_request, 1'b1);
        chk ("al_address", o_bus_address, 32'h00000100);
        ready_drv = 1'b1; rdata_drv = 32'h00100073;
        @(negedge clk);
        ready_drv = 1'b0;
        chk1("al_fetched", o_fetched, 1'b1);
        chk ("al_pc", o_pc, 32'h00000102);
        chk ("al_instruction", o_instruction, 32'h00100073);
`endif
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
